ifu: RTL
========

# ifu

Instruction fetch unit for the multi-cycle MIPS core. Holds the program counter and the instruction register, drives the word address into the 4 KB instruction memory and captures the instruction word it returns. Computes the next PC (sequential, beq-style branch, j/jal, jr) under control of the multi-cycle controller. Flags illegal fetch targets with a sticky fault.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, byte address of the first instruction-memory word.
- IM_BYTES, 4096, size of the instruction-memory window in bytes.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- pc_wr  input  1  PC write enable from the controller.
- ir_wr  input  1  IR write enable from the controller (fetch cycle).
- npc_sel  input  2  next-PC source: 00 SEQ, 01 BR, 10 J, 11 JR.
- br_cond  input  1  branch condition, already evaluated by the ALU/controller.
- rs_data  input  32  register rs value, used as the JR target.
- inst_in  input  32  instruction word from instruction memory at address pc.
- pc  output  32  current PC; connects to the instruction memory address input.
- ir  output  32  instruction register.
- fetch_pc  output  32  byte address of the instruction currently held in ir.
- fetch_fault  output  1  sticky illegal-target flag.

## Operation
- Reset, when rst_n=0 at an edge: pc=PC_RESET, ir=32'h0, fetch_pc=PC_RESET, fetch_fault=0. Reset overrides pc_wr and ir_wr in the same cycle.
- ir_wr=1: ir<=inst_in and fetch_pc<=pc. Both use the pre-update pc, even when pc_wr=1 in the same cycle.
- Candidate next PC (npc), all 32-bit, wrap modulo 2^32:
  - SEQ: pc+4.
  - BR: pc + (sign_ext(ir[15:0])<<2). The pc has already been advanced by the fetch-cycle SEQ write.
  - J: {pc[31:28], ir[25:0], 2'b00}.
  - JR: rs_data.
- PC update on pc_wr=1:
  - npc_sel=BR with br_cond=0: pc holds. This is not a fault and no check is made.
  - Otherwise npc is checked. It is legal when npc[1:0]==0 and IM_BASE <= npc < IM_BASE+IM_BYTES (unsigned compare).
  - Legal: pc<=npc.
  - Illegal: pc holds and fetch_fault<=1.
- While fetch_fault=1, pc_wr and ir_wr are ignored, so pc, ir and fetch_pc freeze. Only reset clears the fault.
- pc_wr=0: pc holds regardless of npc_sel and br_cond.
- No internal FSM sequencing. The controller owns the cycle sequence, and this block obeys its enables every cycle.

## Timing
- pc is a register. inst_in (combinational ROM read of pc) must be valid in the same cycle as ir_wr. ir is valid the cycle after ir_wr.
- New pc is visible the cycle after pc_wr.
- fetch_fault rises the cycle after the offending pc_wr. There is no combinational path from inputs to any output.
- Typical fetch cycle: ir_wr=1, pc_wr=1, npc_sel=SEQ. Next cycle: ir=instruction at the old pc, pc=old pc+4.
- Target check is on npc only. The last legal word (IM_BASE+IM_BYTES-4) executes normally. SEQ past it faults.

## Test plan
- Reset: hold rst_n=0 with pc_wr=ir_wr=1 for 2 cycles. Required: pc=0x3000, ir=0, fetch_pc=0x3000, fetch_fault=0. Release rst_n and do one fetch with inst_in=0x2008_0001. Required: ir=0x2008_0001, fetch_pc=0x3000, pc=0x3004.
- Branch: fetch ir=0x1000_0003 at 0x3000 (pc becomes 0x3004). Then pc_wr, BR, br_cond=1. Required: pc=0x3010. Repeat with imm 0xFFFF: pc=0x3000. Repeat with br_cond=0: pc stays 0x3004, no fault.
- Jump: fetch ir=0x0800_0C05 at 0x3008. Then pc_wr, J. Required: pc=0x0000_3014.
- JR faults: pc_wr, JR, rs_data=0x3002. Required: pc unchanged, fetch_fault=1. Subsequent ir_wr/pc_wr leave pc, ir and fetch_pc frozen. Only rst_n=0 clears it. Repeat with rs_data=0x4000 (out of range) and 0x2FFC (below base): both fault. rs_data=0x3FFC is accepted.
- Boundary: set pc=0x3FFC via JR, then fetch with SEQ. Required: ir captured, fetch_pc=0x3FFC, pc stays 0x3FFC, fetch_fault=1.
- Mid-operation reset: assert rst_n=0 in the same cycle as a legal J write. Required: pc=0x3000 and fault=0 (reset wins).

Source files
------------

// File: rtl/ifu.sv
// Instruction fetch unit: program counter, instruction register and next-PC
// selection for the multi-cycle MIPS core, with a sticky illegal-target fault.
module ifu #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_wr,
    input  logic        ir_wr,
    input  logic [1:0]  npc_sel,
    input  logic        br_cond,
    input  logic [31:0] rs_data,
    input  logic [31:0] inst_in,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic [31:0] fetch_pc,
    output logic        fetch_fault
);

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_J   = 2'b10;
    localparam logic [1:0] SEL_JR  = 2'b11;

    localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + 33'(IM_BYTES);

    logic [31:0]        pc_q, pc_d;
    logic [31:0]        ir_q, ir_d;
    logic [31:0]        fpc_q, fpc_d;
    logic               flt_q, flt_d;
    logic [31:0]        npc;
    logic signed [31:0] br_off;

    // Word-aligned and inside the instruction-memory window (unsigned, no wrap).
    function automatic logic target_ok(input logic [31:0] addr);
        logic [32:0] a;
        a = {1'b0, addr};
        return (addr[1:0] == 2'b00) && (a >= {1'b0, IM_BASE}) && (a < IM_LIMIT);
    endfunction

    always_comb begin
        br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
        npc    = pc_q + 32'd4;
        unique case (npc_sel)
            SEL_SEQ: npc = pc_q + 32'd4;
            SEL_BR:  npc = pc_q + br_off;
            SEL_J:   npc = {pc_q[31:28], ir_q[25:0], 2'b00};
            SEL_JR:  npc = rs_data;
            default: npc = pc_q + 32'd4;
        endcase
    end

    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        fpc_d = fpc_q;
        flt_d = flt_q;
        if (!flt_q) begin
            // Capture uses the pre-update pc even when pc_wr is also set.
            if (ir_wr) begin
                ir_d  = inst_in;
                fpc_d = pc_q;
            end
            if (pc_wr && !(npc_sel == SEL_BR && !br_cond)) begin
                if (target_ok(npc)) begin
                    pc_d = npc;
                end else begin
                    flt_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= PC_RESET;
            ir_q  <= 32'h0;
            fpc_q <= PC_RESET;
            flt_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            fpc_q <= fpc_d;
            flt_q <= flt_d;
        end
    end

    assign pc          = pc_q;
    assign ir          = ir_q;
    assign fetch_pc    = fpc_q;
    assign fetch_fault = flt_q;

endmodule
